// File: rtl/gpio_pkg.sv
// Shared register map, reset values and access types for the per-side GPIO controller.
package gpio_pkg;

  localparam logic [4:0] A_OUT      = 5'h00;
  localparam logic [4:0] A_OE       = 5'h01;
  localparam logic [4:0] A_IE       = 5'h02;
  localparam logic [4:0] A_IN       = 5'h03;
  localparam logic [4:0] A_IRQ_EN   = 5'h04;
  localparam logic [4:0] A_IRQ_RISE = 5'h05;
  localparam logic [4:0] A_IRQ_STAT = 5'h06;
  localparam logic [4:0] A_SET      = 5'h07;
  localparam logic [4:0] A_CLR      = 5'h08;

  localparam logic [31:0] RST_REG = 32'h0;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_RW,
    ACC_RO,
    ACC_WO,
    ACC_W1C
  } acc_t;

  function automatic acc_t acc_type(input logic [4:0] a);
    acc_t t;
    t = ACC_NONE;
    case (a)
      A_OUT, A_OE, A_IE,
      A_IRQ_EN, A_IRQ_RISE: t = ACC_RW;
      A_IN:                 t = ACC_RO;
      A_IRQ_STAT:           t = ACC_W1C;
      A_SET, A_CLR:         t = ACC_WO;
      default:              t = a[4] ? ACC_RW : ACC_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin debounce: output follows input only after 2**DBW-1 consecutive
// mismatching cycles. Used by gpio_side_ctrl when GPIO_DEBOUNCE_EN is defined.
module gpio_debounce #(
  parameter int DBW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  localparam logic [DBW-1:0] LAST = {{(DBW-1){1'b1}}, 1'b0};

  logic [DBW-1:0] r_cnt;
  logic           r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (i_d == r_q) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_q   <= i_d;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/gpio_side_ctrl.sv
// Core-side GPIO controller for one padring side: register port, pad buses,
// input sync, edge interrupts. Optional per-pad debounce via GPIO_DEBOUNCE_EN.
import gpio_pkg::*;

module gpio_side_ctrl #(
  parameter int N    = 9,
  parameter int CFGW = 8,
  parameter int DBW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_valid,
  input  logic            reg_write,
  input  logic [4:0]      reg_addr,
  input  logic [31:0]     reg_wdata,
  output logic            reg_ready,
  output logic            reg_rvalid,
  output logic [31:0]     reg_rdata,
  input  logic [N-1:0]    din,
  output logic [N-1:0]    dout,
  output logic [N-1:0]    oen,
  output logic [N-1:0]    ie,
  output logic [N*CFGW-1:0] cfg,
  output logic            irq
);

  logic [N-1:0]    r_out;
  logic [N-1:0]    r_oe;
  logic [N-1:0]    r_ie;
  logic [N-1:0]    r_irq_en;
  logic [N-1:0]    r_irq_rise;
  logic [N-1:0]    r_irq_stat;
  logic [N-1:0]    r_sync1;
  logic [N-1:0]    r_sync2;
  logic [N-1:0]    r_prev;
  logic [CFGW-1:0] r_cfg [N];
  logic            r_rvalid;
  logic [31:0]     r_rdata;

  logic            w_acc;
  logic            w_wr;
  logic            w_rd;
  logic [N-1:0]    w_wd;
  logic            w_is_cfg;
  logic [3:0]      w_cfg_idx;
  logic [N-1:0]    w_s;
  logic [N-1:0]    w_in;
  logic [N-1:0]    w_rise;
  logic [N-1:0]    w_fall;
  logic [N-1:0]    w_evt;
  logic [N-1:0]    w_w1c;
  logic [N-1:0]    w_mux;
  logic [CFGW-1:0] w_cfg_rd;
  logic            w_readable;
  logic [31:0]     w_rdata;
  acc_t            w_type;
  logic            w_unused;

  assign reg_ready = ~rst;
  assign w_acc     = reg_valid & reg_ready;
  assign w_wr      = w_acc & reg_write;
  assign w_rd      = w_acc & ~reg_write;
  assign w_wd      = reg_wdata[N-1:0];
  assign w_unused  = ^reg_wdata[31:N];

  assign w_cfg_idx = reg_addr[3:0];
  assign w_is_cfg  = reg_addr[4] &
                     ({28'd0, w_cfg_idx} < 32'(N));

  // Input path: sync, gate by IE, optional debounce.
  assign w_s = r_sync2 & r_ie;

`ifdef GPIO_DEBOUNCE_EN
  logic [N-1:0] w_deb;
  for (genvar g = 0; g < N; g++) begin : g_deb
    gpio_debounce #(.DBW(DBW)) u_deb (
      .clk (clk),
      .rst (rst),
      .i_d (w_s[g]),
      .o_q (w_deb[g])
    );
  end
  assign w_in = w_deb & r_ie;
`else
  localparam int unused_dbw = DBW;
  assign w_in = w_s;
`endif

  // Edges are qualified by the registered IE so disabling a pad is silent.
  assign w_rise = w_in & ~r_prev & r_ie;
  assign w_fall = ~w_in & r_prev & r_ie;
  assign w_evt  = (w_rise & r_irq_rise) |
                  (w_fall & ~r_irq_rise);
  assign w_w1c  = (w_wr && reg_addr == A_IRQ_STAT) ?
                  w_wd : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out      <= RST_REG[N-1:0];
      r_oe       <= RST_REG[N-1:0];
      r_ie       <= RST_REG[N-1:0];
      r_irq_en   <= RST_REG[N-1:0];
      r_irq_rise <= RST_REG[N-1:0];
      r_irq_stat <= RST_REG[N-1:0];
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_sync1    <= din;
      r_sync2    <= r_sync1;
      r_prev     <= w_in;
      r_irq_stat <= (r_irq_stat & ~w_w1c) | w_evt;
      r_rvalid   <= w_rd;
      if (w_rd) r_rdata <= w_rdata;
      if (w_wr) begin
        unique case (1'b1)
          reg_addr == A_OUT:      r_out <= w_wd;
          reg_addr == A_OE:       r_oe <= w_wd;
          reg_addr == A_IE:       r_ie <= w_wd;
          reg_addr == A_IRQ_EN:   r_irq_en <= w_wd;
          reg_addr == A_IRQ_RISE: r_irq_rise <= w_wd;
          reg_addr == A_SET:      r_out <= r_out | w_wd;
          reg_addr == A_CLR:      r_out <= r_out & ~w_wd;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst)
        r_cfg[i] <= RST_REG[CFGW-1:0];
      else if (w_wr && w_is_cfg && w_cfg_idx == 4'(i))
        r_cfg[i] <= reg_wdata[CFGW-1:0];
    end
  end

  always_comb begin
    w_cfg_rd = '0;
    for (int i = 0; i < N; i++)
      if (w_cfg_idx == 4'(i)) w_cfg_rd = r_cfg[i];
  end

  always_comb begin
    w_mux = '0;
    unique case (1'b1)
      reg_addr == A_OUT:      w_mux = r_out;
      reg_addr == A_OE:       w_mux = r_oe;
      reg_addr == A_IE:       w_mux = r_ie;
      reg_addr == A_IN:       w_mux = w_in;
      reg_addr == A_IRQ_EN:   w_mux = r_irq_en;
      reg_addr == A_IRQ_RISE: w_mux = r_irq_rise;
      reg_addr == A_IRQ_STAT: w_mux = r_irq_stat;
      default: ;
    endcase
  end

  assign w_type     = acc_type(reg_addr);
  assign w_readable = (w_type == ACC_RW) ||
                      (w_type == ACC_RO) ||
                      (w_type == ACC_W1C);

  always_comb begin
    w_rdata = '0;
    if (w_readable) begin
      if (w_is_cfg)
        w_rdata = {{(32-CFGW){1'b0}}, w_cfg_rd};
      else if (!reg_addr[4])
        w_rdata = {{(32-N){1'b0}}, w_mux};
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cfg
    assign cfg[g*CFGW +: CFGW] = r_cfg[g];
  end

  assign dout       = r_out;
  assign oen        = ~r_oe;
  assign ie         = r_ie;
  assign irq        = |(r_irq_stat & r_irq_en);
  assign reg_rvalid = r_rvalid;
  assign reg_rdata  = r_rdata;

endmodule

// File: tb/tb_gpio_side_ctrl.sv
// Bench for gpio_side_ctrl: register table, scoreboarded reads, edge/irq
// sequences; debounce sequence when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_side_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_valid;
  logic        reg_write;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ready;
  logic        reg_rvalid;
  logic [31:0] reg_rdata;
  logic [8:0]  din;
  logic [8:0]  dout;
  logic [8:0]  oen;
  logic [8:0]  ie;
  logic [71:0] cfg;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    bit          w;
    logic [4:0]  a;
    logic [31:0] d;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[18];

  gpio_side_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .reg_valid  (reg_valid),
    .reg_write  (reg_write),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_ready  (reg_ready),
    .reg_rvalid (reg_rvalid),
    .reg_rdata  (reg_rdata),
    .din        (din),
    .dout       (dout),
    .oen        (oen),
    .ie         (ie),
    .cfg        (cfg),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Advance one cycle; outputs sampled on the falling edge.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    @(negedge clk);
    if (reg_rvalid) begin
      if (sb.size() == 0) begin
        chk("rvalid_extra", 32'(reg_rvalid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk(e.nm, reg_rdata, e.exp);
      end
    end
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    reg_valid = 1'b1;
    reg_write = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    tick();
    reg_valid = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic rd(string nm, logic [4:0] a,
                    logic [31:0] exp);
    sb_t e;
    e.nm  = nm;
    e.exp = exp;
    sb.push_back(e);
    reg_valid = 1'b1;
    reg_write = 1'b0;
    reg_addr  = a;
    tick();
    reg_valid = 1'b0;
    chk({nm, "_lat"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 5'h01, 32'h0000_00F0};
    tbl[1]  = '{1'b0, 5'h01, 32'h0000_00F0};
    tbl[2]  = '{1'b1, 5'h01, 32'hFFFF_FFFF};
    tbl[3]  = '{1'b0, 5'h01, 32'h0000_01FF};
    tbl[4]  = '{1'b1, 5'h05, 32'h0000_01AA};
    tbl[5]  = '{1'b0, 5'h05, 32'h0000_01AA};
    tbl[6]  = '{1'b0, 5'h07, 32'h0};
    tbl[7]  = '{1'b0, 5'h08, 32'h0};
    tbl[8]  = '{1'b1, 5'h18, 32'h0000_005A};
    tbl[9]  = '{1'b0, 5'h18, 32'h0000_005A};
    tbl[10] = '{1'b1, 5'h1F, 32'h0000_00FF};
    tbl[11] = '{1'b0, 5'h1F, 32'h0};
    tbl[12] = '{1'b1, 5'h10, 32'hFFFF_FF3C};
    tbl[13] = '{1'b0, 5'h10, 32'h0000_003C};
    tbl[14] = '{1'b1, 5'h09, 32'h0000_01FF};
    tbl[15] = '{1'b0, 5'h09, 32'h0};
    tbl[16] = '{1'b1, 5'h03, 32'h0000_01FF};
    tbl[17] = '{1'b0, 5'h03, 32'h0};

    rst       = 1'b1;
    reg_valid = 1'b0;
    reg_write = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    din       = '0;
    ticks(3);
    chk("ready_in_rst", 32'(reg_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_oen", 32'(oen), 32'h1FF);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_ie", 32'(ie), 32'h0);
    chk("rst_cfg_hi", 32'(cfg[71:40]), 32'h0);
    chk("rst_cfg_lo", cfg[31:0], 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rvalid", 32'(reg_rvalid), 32'h0);
    chk("rst_rdata", reg_rdata, 32'h0);
    chk("ready", 32'(reg_ready), 32'd1);
    rd("rst_rd_oe", 5'h01, 32'h0);

    wr(5'h00, 32'h0A5);
    wr(5'h07, 32'h100);
    wr(5'h08, 32'h001);
    chk("dout_setclr", 32'(dout), 32'h1A4);
    rd("rd_out", 5'h00, 32'h1A4);
    tick();
    chk("rvalid_pulse", 32'(reg_rvalid), 32'd0);
    rd("b2b_out", 5'h00, 32'h1A4);
    rd("b2b_oe", 5'h01, 32'h0);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].w)
        wr(tbl[i].a, tbl[i].d);
      else
        rd($sformatf("tbl%0d_rd%0h", i, tbl[i].a),
           tbl[i].a, tbl[i].d);
    end
    chk("cfg8", 32'(cfg[71:64]), 32'h5A);
    chk("cfg0", 32'(cfg[7:0]), 32'h3C);
    chk("cfg_mid", cfg[63:32], 32'h0);
    chk("oen_all", 32'(oen), 32'h0);
    chk("dout_keep", 32'(dout), 32'h1A4);
    wr(5'h01, 32'h0);
    chk("oen_off", 32'(oen), 32'h1FF);

`ifndef GPIO_DEBOUNCE_EN
    wr(5'h04, 32'h008);
    wr(5'h05, 32'h008);
    wr(5'h02, 32'h1FF);
    chk("ie_on", 32'(ie), 32'h1FF);
    ticks(2);
    chk("no_irq_idle", 32'(irq), 32'd0);
    din[3] = 1'b1;
    ticks(2);
    chk("irq_lat2", 32'(irq), 32'd0);
    rd("in_pad3", 5'h03, 32'h008);
    chk("irq_rise", 32'(irq), 32'd1);
    rd("stat_rise", 5'h06, 32'h008);

    din[3] = 1'b0;
    ticks(4);
    chk("irq_hold", 32'(irq), 32'd1);
    din[3] = 1'b1;
    ticks(2);
    wr(5'h06, 32'h008);
    chk("set_prio", 32'(irq), 32'd1);
    rd("stat_prio", 5'h06, 32'h008);
    wr(5'h06, 32'h008);
    chk("w1c_clr", 32'(irq), 32'd0);
    rd("stat_clr", 5'h06, 32'h0);

    wr(5'h05, 32'h000);
    wr(5'h02, 32'h000);
    ticks(3);
    chk("ie_off_irq", 32'(irq), 32'd0);
    rd("ie_off_stat", 5'h06, 32'h0);
    rd("ie_off_in", 5'h03, 32'h0);
    wr(5'h02, 32'h1FF);
    ticks(3);
    rd("ie_on_norise", 5'h06, 32'h0);
    din[3] = 1'b0;
    ticks(3);
    chk("irq_fall", 32'(irq), 32'd1);
    rd("stat_fall", 5'h06, 32'h008);
    wr(5'h06, 32'h1FF);
    chk("fall_clr", 32'(irq), 32'd0);
`else
    wr(5'h04, 32'h000);
    wr(5'h02, 32'h1FF);
    din[0] = 1'b1;
    ticks(10);
    din[0] = 1'b0;
    ticks(30);
    rd("deb_glitch", 5'h03, 32'h0);
    din[0] = 1'b1;
    ticks(20);
    rd("deb_level", 5'h03, 32'h001);
    din[0] = 1'b0;
    ticks(20);
    rd("deb_fall", 5'h03, 32'h0);
`endif

    rd("pre_rst_out", 5'h00, 32'h1A4);
    rst       = 1'b1;
    reg_valid = 1'b1;
    reg_write = 1'b0;
    reg_addr  = 5'h00;
    tick();
    chk("rst_rd_norv", 32'(reg_rvalid), 32'd0);
    reg_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst2_rdata", reg_rdata, 32'h0);
    chk("rst2_dout", 32'(dout), 32'h0);
    chk("rst2_oen", 32'(oen), 32'h1FF);
    chk("rst2_cfg", 32'(cfg[71:64]), 32'h0);
    chk("rst2_irq", 32'(irq), 32'd0);
    rd("rst2_stat", 5'h06, 32'h0);
    rd("rst2_cfg8", 5'h18, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
